// File: rtl/conv_line_feeder_if.sv
// Operand-feeder bus: row/weight load handshakes in, (x, w, psum) MAC triples out.
// master = row/weight source and MAC line consumer, slave = conv_line_feeder.
interface conv_line_feeder_if #(
  parameter int I_X    = 8,
  parameter int I_W    = 8,
  parameter int I_PSUM = 16,
  parameter int LW     = 4
);
  logic              i_start;
  logic [LW-1:0]     i_len;
  logic [I_PSUM-1:0] i_bias;
  logic              i_w_valid;
  logic [I_W-1:0]    i_w_data;
  logic              o_w_ready;
  logic              i_x_valid;
  logic [I_X-1:0]    i_x_data;
  logic              o_x_ready;
  logic [I_X-1:0]    o_x;
  logic [I_W-1:0]    o_w;
  logic [I_PSUM-1:0] o_psum;
  logic              o_valid;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_start, i_len, i_bias, i_w_valid, i_w_data, i_x_valid, i_x_data,
    input  o_w_ready, o_x_ready, o_x, o_w, o_psum, o_valid, o_busy, o_done, o_err
  );

  modport slave (
    input  i_start, i_len, i_bias, i_w_valid, i_w_data, i_x_valid, i_x_data,
    output o_w_ready, o_x_ready, o_x, o_w, o_psum, o_valid, o_busy, o_done, o_err
  );
endinterface

// File: rtl/conv_line_feeder.sv
// Buffers K weights and one activation row, then streams (x, w, psum) triples window by window.
// Define CONV_ZERO_PAD_EN for a zero-padded row (P = i_len windows) instead of valid-only convolution.
module conv_line_feeder #(
  parameter int I_X    = 8,
  parameter int I_W    = 8,
  parameter int I_PSUM = 16,
  parameter int K      = 3,
  parameter int N      = 8,
  parameter int LW     = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  conv_line_feeder_if.slave  bus
);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int XA = (N > 1) ? $clog2(N) : 1;
`ifdef CONV_ZERO_PAD_EN
  localparam int PAD     = (K - 1) / 2;
  localparam int LEN_MIN = 1;
`else
  localparam int PAD     = 0;
  localparam int LEN_MIN = K;
`endif
  localparam logic [LW-1:0] LEN_MIN_L = LW'(LEN_MIN);
  localparam logic [LW-1:0] N_L       = LW'(N);
  localparam logic [KW-1:0] K_LAST    = KW'(K - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_STREAM, S_DONE} state_t;

  logic [I_W-1:0]    wbuf [K];
  logic [I_X-1:0]    xbuf [N];

  state_t            state_q;
  logic [KW-1:0]     wcnt_q, k_q, k_d;
  logic [LW-1:0]     xcnt_q, p_q, p_d, len_q;
  logic [I_PSUM-1:0] bias_q, psum_q, psum_d;
  logic [I_X-1:0]    x_q, x_d, x_rd;
  logic [I_W-1:0]    w_q, w_d;
  logic              valid_q, busy_q, done_q, err_q, w_ready_q, x_ready_q;
  logic              w_fire, x_fire, last_tap, last_win, in_range, start_ok;
  logic [LW:0]       sel, sel_off;
  logic [XA-1:0]     x_addr;

  assign w_fire   = bus.i_w_valid && w_ready_q;
  assign x_fire   = bus.i_x_valid && x_ready_q;
  assign start_ok = (bus.i_len >= LEN_MIN_L) && (bus.i_len <= N_L);
  assign last_tap = (k_q == K_LAST);
  assign last_win = (p_q == len_q - LEN_MIN_L);

  // Operands for the triple registered at the next edge; outside STREAM this is triple (0,0).
  always_comb begin
    k_d = '0;
    p_d = '0;
    if (state_q == S_STREAM) begin
      k_d = last_tap ? '0 : k_q + 1'b1;
      p_d = last_tap ? p_q + 1'b1 : p_q;
    end
    sel     = {1'b0, p_d} + (LW+1)'(k_d);
    sel_off = sel - (LW+1)'(PAD);
    // Left-pad positions wrap sel_off far above any legal length, so one compare covers both edges.
    in_range = (sel_off < {1'b0, len_q});
    x_addr   = sel_off[XA-1:0];
    // The last sample may be consumed in the same cycle it is written.
    x_rd   = (x_fire && (sel_off == {1'b0, xcnt_q})) ? bus.i_x_data : xbuf[x_addr];
    x_d    = in_range ? x_rd : '0;
    w_d    = wbuf[k_d];
    psum_d = (k_d == '0) ? bias_q : '0;
  end

  always_ff @(posedge i_clk) begin
    if (w_fire) wbuf[wcnt_q] <= bus.i_w_data;
    if (x_fire) xbuf[xcnt_q[XA-1:0]] <= bus.i_x_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      xcnt_q    <= '0;
      p_q       <= '0;
      k_q       <= '0;
      len_q     <= '0;
      bias_q    <= '0;
      x_q       <= '0;
      w_q       <= '0;
      psum_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      w_ready_q <= 1'b0;
      x_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.i_start) begin
            len_q  <= bus.i_len;
            bias_q <= bus.i_bias;
            if (start_ok) begin
              state_q   <= S_LOAD_W;
              busy_q    <= 1'b1;
              w_ready_q <= 1'b1;
              wcnt_q    <= '0;
              xcnt_q    <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD_W: begin
          if (w_fire) begin
            if (wcnt_q == K_LAST) begin
              state_q   <= S_LOAD_X;
              w_ready_q <= 1'b0;
              x_ready_q <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        S_LOAD_X: begin
          if (x_fire) begin
            if (xcnt_q == len_q - LW'(1)) begin
              state_q   <= S_STREAM;
              x_ready_q <= 1'b0;
              p_q       <= '0;
              k_q       <= '0;
              valid_q   <= 1'b1;
              x_q       <= x_d;
              w_q       <= w_d;
              psum_q    <= psum_d;
            end else begin
              xcnt_q <= xcnt_q + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (last_tap && last_win) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
            x_q     <= '0;
            w_q     <= '0;
            psum_q  <= '0;
            done_q  <= 1'b1;
          end else begin
            p_q     <= p_d;
            k_q     <= k_d;
            x_q     <= x_d;
            w_q     <= w_d;
            psum_q  <= psum_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          valid_q   <= 1'b0;
          w_ready_q <= 1'b0;
          x_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_w_ready = w_ready_q;
  assign bus.o_x_ready = x_ready_q;
  assign bus.o_x       = x_q;
  assign bus.o_w       = w_q;
  assign bus.o_psum    = psum_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_err     = err_q;
endmodule

// File: tb/tb_conv_line_feeder.sv
// Directed bench for conv_line_feeder: basic row, x gaps, length bounds, mid-stream reset, start while busy.
// Expected tables follow the CONV_ZERO_PAD_EN setting of the build.
module tb_conv_line_feeder;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_line_feeder_if bus ();

  conv_line_feeder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  localparam logic [7:0] WV [3] = '{8'd50, 8'd5, 8'd15};
  localparam logic [7:0] XV [5] = '{8'd100, 8'd10, 8'd100, 8'd20, 8'd100};
`ifdef CONV_ZERO_PAD_EN
  localparam int EXP_N  = 15;
  localparam int N_LEN3 = 9;
  localparam logic [LW-1:0] BAD_LO = 4'd0;
  localparam logic [31:0] EXP [15] = '{
    {8'd0,   8'd50, 16'd7}, {8'd100, 8'd5, 16'd0}, {8'd10,  8'd15, 16'd0},
    {8'd100, 8'd50, 16'd7}, {8'd10,  8'd5, 16'd0}, {8'd100, 8'd15, 16'd0},
    {8'd10,  8'd50, 16'd7}, {8'd100, 8'd5, 16'd0}, {8'd20,  8'd15, 16'd0},
    {8'd100, 8'd50, 16'd7}, {8'd20,  8'd5, 16'd0}, {8'd100, 8'd15, 16'd0},
    {8'd20,  8'd50, 16'd7}, {8'd100, 8'd5, 16'd0}, {8'd0,   8'd15, 16'd0}};
`else
  localparam int EXP_N  = 9;
  localparam int N_LEN3 = 3;
  localparam logic [LW-1:0] BAD_LO = 4'd2;
  localparam logic [31:0] EXP [9] = '{
    {8'd100, 8'd50, 16'd7}, {8'd10,  8'd5, 16'd0}, {8'd100, 8'd15, 16'd0},
    {8'd10,  8'd50, 16'd7}, {8'd100, 8'd5, 16'd0}, {8'd20,  8'd15, 16'd0},
    {8'd100, 8'd50, 16'd7}, {8'd20,  8'd5, 16'd0}, {8'd100, 8'd15, 16'd0}};
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lx_cyc = 0;

  logic [31:0] trip_q [$];
  int          tcyc_q [$];
  int          done_n = 0;
  int          done_cyc = 0;
  int          err_n = 0;
  int          rdy_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_valid) begin
      trip_q.push_back({bus.o_x, bus.o_w, bus.o_psum});
      tcyc_q.push_back(cyc);
      $display("cyc %0d triple x=%0d w=%0d psum=%0d", cyc, bus.o_x, bus.o_w, bus.o_psum);
    end
    if (bus.o_done) begin
      done_n++;
      done_cyc = cyc;
    end
    if (bus.o_err) err_n++;
    if (bus.o_w_ready || bus.o_x_ready) rdy_n++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [LW-1:0] len);
    bus.i_start = 1'b1;
    bus.i_len   = len;
    bus.i_bias  = 16'd7;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic send_w(input logic [7:0] d);
    int t = 0;
    bus.i_w_valid = 1'b1;
    bus.i_w_data  = d;
    while (!bus.o_w_ready && t < 20) begin tick(); t++; end
    chk("w_ready", 32'(bus.o_w_ready), 32'd1);
    tick();
    bus.i_w_valid = 1'b0;
  endtask

  task automatic send_x(input logic [7:0] d, input bit gap, input bit pulse);
    int t = 0;
    bus.i_x_valid = 1'b1;
    bus.i_x_data  = d;
    while (!bus.o_x_ready && t < 20) begin tick(); t++; end
    chk("x_ready", 32'(bus.o_x_ready), 32'd1);
    lx_cyc = cyc;
    if (pulse) begin
      bus.i_start = 1'b1;
      bus.i_len   = 4'd4;
    end
    tick();
    bus.i_start   = 1'b0;
    bus.i_x_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic run_row(input string name, input logic [LW-1:0] len, input bit gap,
                         input bit pulse_lx, input bit pulse_st, input int n_exp, input int n_cmp);
    int bt = trip_q.size();
    int bd = done_n;
    int be = err_n;
    int t = 0;
    start(len);
    for (int k = 0; k < 3; k++) send_w(WV[k]);
    for (int i = 0; i < int'(len); i++) send_x(XV[i], gap, pulse_lx && (i == 2));
    if (pulse_st) begin
      bus.i_start = 1'b1;
      bus.i_len   = 4'd2;
      tick();
      bus.i_start = 1'b0;
    end
    while (done_n == bd && t < 100) begin tick(); t++; end
    tick();
    tick();
    chk({name, "_done_cnt"}, 32'(done_n - bd), 32'd1);
    chk({name, "_n_valid"}, 32'(trip_q.size() - bt), 32'(n_exp));
    for (int i = 0; i < n_cmp; i++)
      if (bt + i < trip_q.size()) chk($sformatf("%s_trip%0d", name, i), trip_q[bt + i], EXP[i]);
    if (trip_q.size() > bt) begin
      chk({name, "_first_lat"}, 32'(tcyc_q[bt]), 32'(lx_cyc + 1));
      chk({name, "_done_lat"}, 32'(done_cyc), 32'(tcyc_q[trip_q.size() - 1] + 1));
    end
    chk({name, "_no_err"}, 32'(err_n - be), 32'd0);
    chk({name, "_idle"}, {30'd0, bus.o_busy, bus.o_w_ready}, 32'd0);
  endtask

  task automatic bad_len(input string name, input logic [LW-1:0] len);
    int bt = trip_q.size();
    int be = err_n;
    int br = rdy_n;
    start(len);
    chk({name, "_err_now"}, 32'(bus.o_err), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk({name, "_err_cnt"}, 32'(err_n - be), 32'd1);
    chk({name, "_no_ready"}, 32'(rdy_n - br), 32'd0);
    chk({name, "_no_valid"}, 32'(trip_q.size() - bt), 32'd0);
    chk({name, "_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int bt;
    int t;
    bus.i_start = 1'b0;  bus.i_len = '0;      bus.i_bias = '0;
    bus.i_w_valid = 1'b0; bus.i_w_data = '0;
    bus.i_x_valid = 1'b0; bus.i_x_data = '0;
    tick();
    tick();
    chk("rst_ctrl", {26'd0, bus.o_valid, bus.o_busy, bus.o_done, bus.o_err, bus.o_w_ready, bus.o_x_ready}, 32'd0);
    chk("rst_data", {bus.o_x, bus.o_w, bus.o_psum}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_row("basic", 4'd5, 1'b0, 1'b0, 1'b0, EXP_N, EXP_N);
    run_row("gaps", 4'd5, 1'b1, 1'b0, 1'b0, EXP_N, EXP_N);

    bt = trip_q.size();
    t = 0;
    start(4'd5);
    for (int k = 0; k < 3; k++) send_w(WV[k]);
    for (int i = 0; i < 5; i++) send_x(XV[i], 1'b0, 1'b0);
    while (trip_q.size() - bt < 4 && t < 50) begin tick(); t++; end
    chk("mid_valid_before", 32'(bus.o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {26'd0, bus.o_valid, bus.o_busy, bus.o_done, bus.o_err, bus.o_w_ready, bus.o_x_ready}, 32'd0);
    chk("mid_rst_data", {bus.o_x, bus.o_w, bus.o_psum}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_row("restart", 4'd5, 1'b0, 1'b0, 1'b0, EXP_N, EXP_N);

    run_row("busy_start", 4'd5, 1'b0, 1'b1, 1'b1, EXP_N, EXP_N);

    bad_len("len_lo", BAD_LO);
    bad_len("len_hi", 4'd9);
    run_row("len3", 4'd3, 1'b0, 1'b0, 1'b0, N_LEN3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
